phase_timer: RTL and testbench

Parametrised phase-duration timer for the traffic-light controller. It serves any number of one-hot FSM phases, not only green/yellow/red. It counts in prescaled ticks (e.g. seconds) rather than raw clocks, and holds a runtime-writable duration per phase. It also supports hold/freeze and gives a remaining-time output for the countdown display. It sits between the light FSM (which supplies `phase_sel` and consumes `phase_end`) and the display driver (which consumes `remain`).

---
 rtl/phase_timer_pkg.sv | 24 ++
 rtl/phase_timer_if.sv | 42 ++++
 rtl/phase_timer_tick_prescaler.sv | 47 ++++
 rtl/phase_timer.sv | 97 +++++++++
 tb/tb_phase_timer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/phase_timer_pkg.sv
// -----------------------------------------------------------------------------
// phase_timer_pkg
// Shared traffic-light definitions used by the phase timer, its bus interface
// and the light FSM.
//   phase_e            : phase index constants (one bit of phase_sel each)
//   DEF_NUM_PHASES     : default number of phases (green, yellow, red)
//   DEF_CNT_W          : default width of durations and counters
//   DEF_PHASE_TIMES    : default per-phase durations in ticks, slice i = phase i
// -----------------------------------------------------------------------------
package phase_timer_pkg;

   typedef enum int unsigned {
      PH_GREEN  = 0,
      PH_YELLOW = 1,
      PH_RED    = 2
   } phase_e;

   localparam int DEF_NUM_PHASES = 3;
   localparam int DEF_CNT_W      = 8;

   // Packed with phase 0 in the least significant slice: red=3, yellow=5, green=30.
   localparam logic [DEF_NUM_PHASES*DEF_CNT_W-1:0] DEF_PHASE_TIMES = {8'd3, 8'd5, 8'd30};

endpackage

// File: rtl/phase_timer_if.sv
// -----------------------------------------------------------------------------
// phase_timer_if
// Bus between the light FSM / configuration master and the phase timer.
//   phase_sel  : one-hot active phase           (master -> timer)
//   hold       : freeze timing while high       (master -> timer)
//   cfg_we     : duration write strobe          (master -> timer)
//   cfg_idx    : phase index to write           (master -> timer)
//   cfg_time   : new duration in ticks          (master -> timer)
//   phase_end  : one-cycle end pulse per phase  (timer -> master)
//   remain     : ticks left in current phase    (timer -> master)
//   tick       : prescaler tick pulse           (timer -> master)
//   sel_err    : phase_sel zero or multi-hot    (timer -> master)
// -----------------------------------------------------------------------------
interface phase_timer_if
   import phase_timer_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int CNT_W      = DEF_CNT_W
);
   localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   logic [NUM_PHASES-1:0] phase_sel;
   logic                  hold;
   logic                  cfg_we;
   logic [IDX_W-1:0]      cfg_idx;
   logic [CNT_W-1:0]      cfg_time;
   logic [NUM_PHASES-1:0] phase_end;
   logic [CNT_W-1:0]      remain;
   logic                  tick;
   logic                  sel_err;

   modport master (
      output phase_sel, hold, cfg_we, cfg_idx, cfg_time,
      input  phase_end, remain, tick, sel_err
   );

   modport slave (
      input  phase_sel, hold, cfg_we, cfg_idx, cfg_time,
      output phase_end, remain, tick, sel_err
   );

endinterface

// File: rtl/phase_timer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to one tick pulse every PRESC_DIV clocks.
//   clk     : clock
//   rst_n   : synchronous active-low reset, also masks tick_o
//   clr_i   : restart the count from 0 (has priority over freeze)
//   frz_i   : hold the count and suppress tick_o
//   tick_o  : combinational one-cycle tick, high when the count is at its last value
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int unsigned PRESC_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic frz_i,
   output logic tick_o
);
   localparam int               PRE_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PRE_W-1:0] LAST_CNT = PRE_W'(PRESC_DIV - 1);

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

   assign tick_o = rst_n && !clr_i && !frz_i && (pre_cnt_q == LAST_CNT);

   always_comb begin
      // NOTE: default first so every path assigns pre_cnt_d and no latch is inferred.
      pre_cnt_d = pre_cnt_q;
      if (clr_i) begin
         pre_cnt_d = '0;
      end else if (tick_o) begin
         pre_cnt_d = '0;
      end else if (!frz_i) begin
         pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Phase-duration timer for the traffic-light FSM. Counts prescaled ticks per
// one-hot phase, holds a runtime-writable duration per phase and reports the
// remaining ticks for the countdown display.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : phase_timer_if.slave (phase_sel, hold, cfg_* in;
//            phase_end, remain, tick, sel_err out, all outputs combinational)
// -----------------------------------------------------------------------------
module phase_timer
   import phase_timer_pkg::*;
#(
   parameter int                            NUM_PHASES = DEF_NUM_PHASES,
   parameter int                            CNT_W      = DEF_CNT_W,
   parameter int unsigned                   PRESC_DIV  = 50_000_000,
   parameter logic [NUM_PHASES*CNT_W-1:0]   DEF_TIMES  = DEF_PHASE_TIMES
) (
   input  logic          clk,
   input  logic          rst_n,
   phase_timer_if.slave  bus
);
   localparam int                    IDX_W   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam logic [NUM_PHASES-1:0] SEL_ONE = NUM_PHASES'(1);

   logic [CNT_W-1:0]      dur_q [NUM_PHASES];
   logic [CNT_W-1:0]      elapsed_q, elapsed_d;
   logic [NUM_PHASES-1:0] sel_q;
   logic [CNT_W-1:0]      dur_sel, dur_eff;
   logic                  sel_err, change, tick, done;

   // Zero or more than one bit set.
   assign sel_err = (bus.phase_sel == '0) ||
                    ((bus.phase_sel & (bus.phase_sel - SEL_ONE)) != '0);

   // A new valid phase restarts timing even while hold is high.
   assign change = (bus.phase_sel != sel_q) && !sel_err;

   tick_prescaler #(
      .PRESC_DIV (PRESC_DIV)
   ) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (change),
      .frz_i  (bus.hold || sel_err),
      .tick_o (tick)
   );

   always_comb begin
      dur_sel = '0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (bus.phase_sel[i]) dur_sel = dur_q[i];
      end
   end

   // A stored duration of 0 behaves as 1 so the phase still ends.
   assign dur_eff = (dur_sel == '0) ? CNT_W'(1) : dur_sel;

   // One extra bit so elapsed+1 cannot wrap at the all-ones duration.
   assign done = tick &&
                 (({1'b0, elapsed_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, dur_eff});

   always_comb begin
      elapsed_d = elapsed_q;
      if (change) begin
         elapsed_d = '0;
      end else if (tick) begin
         elapsed_d = done ? '0 : elapsed_q + CNT_W'(1);
      end
   end

   assign bus.tick      = tick;
   assign bus.sel_err   = sel_err;
   assign bus.phase_end = done ? bus.phase_sel : '0;
   // Saturates when a shrinking write leaves elapsed beyond the new duration.
   assign bus.remain    = sel_err               ? '0 :
                          (dur_eff > elapsed_q) ? dur_eff - elapsed_q : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         elapsed_q <= '0;
         sel_q     <= '0;
         // NOTE: the duration array is reset on purpose: DEF_TIMES must come back after any writes.
         for (int i = 0; i < NUM_PHASES; i++) begin
            dur_q[i] <= DEF_TIMES[i*CNT_W +: CNT_W];
         end
      end else begin
         elapsed_q <= elapsed_d;
         sel_q     <= bus.phase_sel;
         // Indices with no matching phase simply match nothing and are dropped.
         for (int i = 0; i < NUM_PHASES; i++) begin
            if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) dur_q[i] <= bus.cfg_time;
         end
      end
   end

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
// Directed bench for phase_timer. dut_a runs with PRESC_DIV=1 and the default
// durations; dut_b runs with PRESC_DIV=4 and a 3-tick green phase and only
// sees phase_sel=green from reset release. Expected outputs are queued when a
// cycle's stimulus is applied and popped at the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_phase_timer;
   import phase_timer_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   phase_timer_if #(.NUM_PHASES(3), .CNT_W(8)) bus_a ();
   phase_timer_if #(.NUM_PHASES(3), .CNT_W(8)) bus_b ();

   phase_timer #(
      .NUM_PHASES (3),
      .CNT_W      (8),
      .PRESC_DIV  (1)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   phase_timer #(
      .NUM_PHASES (3),
      .CNT_W      (8),
      .PRESC_DIV  (4),
      .DEF_TIMES  ({8'd30, 8'd5, 8'd3})
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   localparam logic [2:0] GRN = 3'b001 << PH_GREEN;
   localparam logic [2:0] YEL = 3'b001 << PH_YELLOW;
   localparam logic [2:0] RED = 3'b001 << PH_RED;

   typedef struct packed {
      logic [2:0] pe;
      logic [7:0] remain;
      logic       tick;
      logic       err;
   } exp_t;

   exp_t  qa[$];
   exp_t  qb[$];
   int    errors  = 0;
   int    checks  = 0;
   int    cyc     = 0;
   int    b_cyc   = -1;
   string cur_tag = "init";

   task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s c%0d %s observed=%0d expected=%0d", cur_tag, cyc, name, obs, exp);
      end
   endtask

   // One clock cycle: queue expectations, compare at the falling edge, then
   // return 1 time unit after the next rising edge, ready for new stimulus.
   task automatic step(input logic [2:0] pe, input logic [7:0] rem, input logic tk, input logic er);
      exp_t ea;
      exp_t eb;
      qa.push_back('{pe: pe, remain: rem, tick: tk, err: er});
      // dut_b: ticks every 4th cycle, green (3 ticks) ends at cycle 12.
      if (b_cyc >= 0 && b_cyc <= 15) begin
         qb.push_back('{pe:     (b_cyc == 12) ? GRN : 3'b000,
                        remain: (b_cyc == 0) ? 8'd3 : 8'(3 - ((b_cyc - 1) / 4) % 3),
                        tick:   (b_cyc > 0) && (b_cyc % 4 == 0),
                        err:    1'b0});
      end
      @(negedge clk);
      ea = qa.pop_front();
      chk("a.phase_end", {13'd0, bus_a.phase_end}, {13'd0, ea.pe});
      chk("a.remain",    {8'd0, bus_a.remain},     {8'd0, ea.remain});
      chk("a.tick",      {15'd0, bus_a.tick},      {15'd0, ea.tick});
      chk("a.sel_err",   {15'd0, bus_a.sel_err},   {15'd0, ea.err});
      if (qb.size() != 0) begin
         eb = qb.pop_front();
         chk("b.phase_end", {13'd0, bus_b.phase_end}, {13'd0, eb.pe});
         chk("b.remain",    {8'd0, bus_b.remain},     {8'd0, eb.remain});
         chk("b.tick",      {15'd0, bus_b.tick},      {15'd0, eb.tick});
      end
      if (b_cyc >= 0) b_cyc++;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Cycles from..to (>= 1) of an undisturbed phase of d ticks at PRESC_DIV=1:
   // a tick every cycle, remain counts d..1 and the end pulse repeats every d cycles.
   task automatic run_norm(input logic [2:0] sel, input int d, input int from, input int to);
      for (int c = from; c <= to; c++) begin
         int k = (c - 1) % d;
         step((k == d - 1) ? sel : 3'b000, 8'(d - k), 1'b1, 1'b0);
      end
   endtask

   initial begin
      bus_a.phase_sel = GRN;
      bus_a.hold      = 1'b0;
      bus_a.cfg_we    = 1'b0;
      bus_a.cfg_idx   = '0;
      bus_a.cfg_time  = '0;
      bus_b.phase_sel = GRN;
      bus_b.hold      = 1'b0;
      bus_b.cfg_we    = 1'b0;
      bus_b.cfg_idx   = '0;
      bus_b.cfg_time  = '0;

      // Reset: registers cleared, no pulses, remain shows green's default.
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      cur_tag = "reset";
      step(3'b000, 8'd30, 1'b0, 1'b0);
      rst_n = 1'b1;
      b_cyc = 0;

      // Defaults: green ends at cycle 30, yellow at cycle 5.
      cur_tag = "green_default";
      step(3'b000, 8'd30, 1'b0, 1'b0);
      run_norm(GRN, 30, 1, 31);
      cur_tag = "yellow_default";
      bus_a.phase_sel = YEL;
      step(3'b000, 8'd4, 1'b0, 1'b0);      // elapsed still 1 from green
      run_norm(YEL, 5, 1, 6);

      // Hold for 7 cycles from cycle 10: remain frozen, end moves to cycle 37.
      cur_tag = "hold";
      bus_a.phase_sel = GRN;
      step(3'b000, 8'd29, 1'b0, 1'b0);
      run_norm(GRN, 30, 1, 9);
      bus_a.hold = 1'b1;
      for (int i = 0; i < 7; i++) step(3'b000, 8'd21, 1'b0, 1'b0);
      bus_a.hold = 1'b0;
      run_norm(GRN, 30, 10, 31);

      // Short red phase, then a fresh green for the config tests.
      cur_tag = "red_short";
      bus_a.phase_sel = RED;
      step(3'b000, 8'd2, 1'b0, 1'b0);
      run_norm(RED, 3, 1, 3);

      // Shrink green to 5 at cycle 12: old duration that cycle, end at 13.
      cur_tag = "cfg_shrink";
      bus_a.phase_sel = GRN;
      step(3'b000, 8'd30, 1'b0, 1'b0);
      run_norm(GRN, 30, 1, 11);
      bus_a.cfg_we   = 1'b1;
      bus_a.cfg_idx  = 2'd0;
      bus_a.cfg_time = 8'd5;
      run_norm(GRN, 30, 12, 12);
      bus_a.cfg_we = 1'b0;
      step(GRN, 8'd0, 1'b1, 1'b0);
      run_norm(GRN, 5, 1, 5);

      // Write to index 3 does nothing.
      cur_tag = "cfg_idx3";
      bus_a.cfg_we   = 1'b1;
      bus_a.cfg_idx  = 2'd3;
      bus_a.cfg_time = 8'd7;
      run_norm(GRN, 5, 1, 1);
      bus_a.cfg_we = 1'b0;
      run_norm(GRN, 5, 2, 5);

      // Duration 0 acts as 1: phase ends on every tick.
      cur_tag = "cfg_zero";
      bus_a.cfg_we   = 1'b1;
      bus_a.cfg_idx  = 2'd0;
      bus_a.cfg_time = 8'd0;
      run_norm(GRN, 5, 1, 1);
      bus_a.cfg_we = 1'b0;
      step(GRN, 8'd0, 1'b1, 1'b0);
      run_norm(GRN, 1, 1, 2);
      bus_a.cfg_we   = 1'b1;
      bus_a.cfg_time = 8'd20;
      run_norm(GRN, 1, 1, 1);
      bus_a.cfg_we = 1'b0;
      run_norm(GRN, 20, 1, 5);

      // Invalid select for 4 cycles, then green restarts from cycle 0.
      cur_tag = "sel_err";
      bus_a.phase_sel = 3'b011;
      for (int i = 0; i < 4; i++) step(3'b000, 8'd0, 1'b0, 1'b1);
      bus_a.phase_sel = GRN;
      step(3'b000, 8'd15, 1'b0, 1'b0);
      run_norm(GRN, 20, 1, 20);

      // Reset mid-red after a yellow write: everything back to defaults.
      cur_tag = "reset_mid";
      bus_a.phase_sel = RED;
      step(3'b000, 8'd3, 1'b0, 1'b0);
      bus_a.cfg_we   = 1'b1;
      bus_a.cfg_idx  = 2'd1;
      bus_a.cfg_time = 8'd9;
      run_norm(RED, 3, 1, 1);
      bus_a.cfg_we = 1'b0;
      rst_n = 1'b0;
      step(3'b000, 8'd2, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(3'b000, 8'd3, 1'b0, 1'b0);
      run_norm(RED, 3, 1, 3);
      cur_tag = "restored_yellow";
      bus_a.phase_sel = YEL;
      step(3'b000, 8'd5, 1'b0, 1'b0);
      run_norm(YEL, 5, 1, 5);
      cur_tag = "restored_green";
      bus_a.phase_sel = GRN;
      step(3'b000, 8'd30, 1'b0, 1'b0);
      run_norm(GRN, 30, 1, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
